// File: rtl/ti_coord_eval_pipe.sv
// Loadable-truth-table evaluator for threshold-implementation S-box coordinate functions.
// Share vectors stream through two glitch-isolating register stages with valid/ready handshakes.
module ti_coord_eval_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_done,
    input  logic             cfg_start,
    output logic             cfg_err,
    output logic             tbl_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int DEPTH = 1 << IN_W;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic              tbl_ready_r;
    logic              cfg_err_r;
    logic [OUT_W-1:0]  tbl_r [DEPTH];
    logic              a_valid_r;
    logic [IN_W-1:0]   a_data_r;
    logic              b_valid_r;
    logic [OUT_W-1:0]  b_data_r;

    logic              b_adv_s;
    logic              a_adv_s;
    logic              accept_s;
    logic              wr_en_s;

    // Stage advance conditions; the ready path is combinational from out_ready.
    always_comb begin
        b_adv_s  = 1'b0;
        a_adv_s  = 1'b0;
        accept_s = 1'b0;
        wr_en_s  = 1'b0;
        b_adv_s  = !b_valid_r || out_ready;
        a_adv_s  = !a_valid_r || b_adv_s;
        accept_s = in_valid && (state_r == ST_RUN) && a_adv_s;
        wr_en_s  = cfg_we && (state_r == ST_CFG);
    end

    // Mode FSM with registered table-ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CFG;
            tbl_ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CFG: begin
                    if (cfg_done) begin
                        state_r     <= ST_RUN;
                        tbl_ready_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CFG;
                        tbl_ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cfg_start) begin
                        state_r     <= ST_DRAIN;
                        tbl_ready_r <= 1'b0;
                    end else begin
                        state_r     <= ST_RUN;
                        tbl_ready_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave only once both stages have emptied.
                    if (!a_valid_r && !b_valid_r) begin
                        state_r <= ST_CFG;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                    tbl_ready_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_CFG;
                    tbl_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky misuse flag: a table write attempted outside configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else if (cfg_we && (state_r != ST_CFG)) begin
            cfg_err_r <= 1'b1;
        end else begin
            cfg_err_r <= cfg_err_r;
        end
    end

    // One register per table row so the whole table clears on reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tbl_r[gi] <= '0;
            end else if (wr_en_s && (cfg_addr == IN_W'(gi))) begin
                tbl_r[gi] <= cfg_data;
            end else begin
                tbl_r[gi] <= tbl_r[gi];
            end
        end
    end

    // Two-stage elastic pipeline: A captures shares, B captures the lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_data_r  <= '0;
            b_valid_r <= 1'b0;
            b_data_r  <= '0;
        end else begin
            if (a_adv_s) begin
                a_valid_r <= accept_s;
                if (accept_s) begin
                    a_data_r <= in_data;
                end
            end
            if (b_adv_s) begin
                b_valid_r <= a_valid_r;
                if (a_valid_r) begin
                    b_data_r <= tbl_r[a_data_r];
                end
            end
        end
    end

    assign in_ready  = (state_r == ST_RUN) && a_adv_s;
    assign tbl_ready = tbl_ready_r;
    assign cfg_err   = cfg_err_r;
    assign out_valid = b_valid_r;
    assign out_data  = b_data_r;

endmodule
